mc_seq_core: RTL and testbench

- Parametrised multicycle instruction sequencer: the next-generation control core for the team's multicycle processor.
- Owns the program counter, instruction register and main control FSM.
- Fetches over a ready-handshaked instruction port and waits on a ready-handshaked data port. Previous generation assumed single-cycle memories.
- Drives datapath strobes, evaluates BEQ/BNE with the ALU zero flag, handles a hold/stall input and counts retired instructions.

---
 rtl/mc_seq_pkg.sv | 28 ++
 rtl/mc_seq_pc.sv | 30 +++
 rtl/mc_seq_core.sv | 148 ++++++++++++++
 tb/tb_mc_seq_core.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mc_seq_pkg.sv
// Shared types and constants for the multicycle sequencer: FSM state encoding,
// opcode map and default widths.
package mc_seq_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'd0;
    localparam logic [3:0] OP_LW    = 4'd1;
    localparam logic [3:0] OP_SW    = 4'd2;
    localparam logic [3:0] OP_BEQ   = 4'd3;
    localparam logic [3:0] OP_BNE   = 4'd4;
    localparam logic [3:0] OP_JMP   = 4'd5;
    localparam logic [3:0] OP_ADDI  = 4'd6;
    localparam logic [3:0] OP_HALT  = 4'd15;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_OPC_W  = 4;
    localparam int unsigned DEF_CNT_W  = 32;

endpackage

// File: rtl/mc_seq_pc.sv
// Program counter: reset value, branch/jump load, per-fetch increment with
// natural modulo-2^ADDR_W wrap; holds otherwise.
module mc_seq_pc #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned PC_INC   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_val,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_pc
);

    logic [ADDR_W-1:0] r_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= ADDR_W'(RESET_PC);
        end else if (i_load) begin
            r_pc <= i_load_val;
        end else if (i_inc) begin
            r_pc <= r_pc + ADDR_W'(PC_INC);
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/mc_seq_core.sv
// Multicycle instruction sequencer: PC, IR, control FSM and retire counter.
// Optional wait-state watchdog is compiled in with MC_SEQ_WDOG_EN.
module mc_seq_core
    import mc_seq_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned OPC_W       = DEF_OPC_W,
    parameter int unsigned RESET_PC    = 0,
    parameter int unsigned PC_INC      = 2,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned WDOG_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              dmem_ready,
    input  logic              alu_zero,
    input  logic [ADDR_W-1:0] alu_result,
    input  logic              stall,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instr,
    output logic [OPC_W-1:0]  opcode,
    output logic [2:0]        state,
    output logic              ir_write,
    output logic              reg_write,
    output logic              mem_to_reg,
    output logic              mem_read,
    output logic              mem_write,
    output logic              illegal,
    output logic              halted,
    output logic [CNT_W-1:0]  instret,
    output logic              wdog_err
);

    state_t            r_state;
    logic [DATA_W-1:0] r_instr;
    logic [CNT_W-1:0]  r_instret;
    logic [OPC_W-1:0]  w_opc;
    logic              w_fetch_done, w_exec_go, w_is_lw, w_is_sw;
    logic              w_taken, w_ctrl, w_known, w_retire;

    assign w_opc        = r_instr[DATA_W-1 -: OPC_W];
    assign w_fetch_done = (r_state == S_FETCH) && imem_ready;
    assign w_exec_go    = (r_state == S_EXEC) && !stall;
    assign w_is_lw      = (w_opc == OPC_W'(OP_LW));
    assign w_is_sw      = (w_opc == OPC_W'(OP_SW));

    // Control-transfer decode used in EXEC; anything unlisted is illegal.
    always_comb begin
        w_taken = 1'b0;
        w_ctrl  = 1'b0;
        w_known = 1'b1;
        case (w_opc)
            OPC_W'(OP_BEQ): begin w_taken = alu_zero;  w_ctrl = 1'b1; end
            OPC_W'(OP_BNE): begin w_taken = !alu_zero; w_ctrl = 1'b1; end
            OPC_W'(OP_JMP): begin w_taken = 1'b1;      w_ctrl = 1'b1; end
            OPC_W'(OP_RTYPE), OPC_W'(OP_ADDI), OPC_W'(OP_LW), OPC_W'(OP_SW): ;
            default: w_known = 1'b0;
        endcase
    end

    assign w_retire = (w_exec_go && w_ctrl)
                   || ((r_state == S_MEM) && dmem_ready && w_is_sw)
                   || ((r_state == S_WB) && !stall);

    mc_seq_pc #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC),
        .PC_INC   (PC_INC)
    ) u_pc (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_exec_go && w_taken),
        .i_load_val (alu_result),
        .i_inc      (w_fetch_done),
        .o_pc       (pc)
    );

`ifdef MC_SEQ_WDOG_EN
    localparam int unsigned WAIT_W = $clog2(WDOG_CYCLES + 1);
    logic [WAIT_W-1:0] r_wait;
    logic              r_wdog_err;
    logic              w_wait, w_trip;

    assign w_wait   = ((r_state == S_FETCH) && !imem_ready) || ((r_state == S_MEM) && !dmem_ready);
    assign w_trip   = w_wait && (r_wait == WAIT_W'(WDOG_CYCLES - 1));
    assign wdog_err = r_wdog_err;
`else
    assign wdog_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_FETCH;
            r_instr   <= '0;
            r_instret <= '0;
`ifdef MC_SEQ_WDOG_EN
            r_wait     <= '0;
            r_wdog_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_FETCH: if (imem_ready) begin
                    r_instr <= imem_rdata;
                    r_state <= S_DECODE;
                end
                S_DECODE: if (!stall) r_state <= (w_opc == OPC_W'(OP_HALT)) ? S_HALT : S_EXEC;
                S_EXEC: if (!stall) begin
                    if (w_ctrl || !w_known) r_state <= S_FETCH;
                    else if (w_is_lw || w_is_sw) r_state <= S_MEM;
                    else r_state <= S_WB;
                end
                S_MEM: if (dmem_ready) r_state <= w_is_lw ? S_WB : S_FETCH;
                S_WB: if (!stall) r_state <= S_FETCH;
                S_HALT: r_state <= S_HALT;
                default: r_state <= S_FETCH;
            endcase
            if (w_retire) r_instret <= r_instret + 1'b1;
`ifdef MC_SEQ_WDOG_EN
            // The counter only runs while parked on a wait, so any state change clears it.
            r_wait <= w_wait ? r_wait + 1'b1 : '0;
            if (w_trip) begin
                r_wdog_err <= 1'b1;
                r_state    <= S_HALT;
            end
`endif
        end
    end

    assign imem_req   = rst && (r_state == S_FETCH);
    assign imem_addr  = pc;
    assign ir_write   = rst && w_fetch_done;
    assign reg_write  = (r_state == S_WB) && !stall;
    assign mem_to_reg = (r_state == S_WB) && !stall && w_is_lw;
    assign mem_read   = (r_state == S_MEM) && w_is_lw;
    assign mem_write  = (r_state == S_MEM) && w_is_sw;
    assign illegal    = w_exec_go && !w_known;
    assign halted     = (r_state == S_HALT);
    assign instr      = r_instr;
    assign opcode     = w_opc;
    assign state      = r_state;
    assign instret    = r_instret;

endmodule

// File: tb/tb_mc_seq_core.sv
// Directed bench for mc_seq_core: fetch/decode/exec flows, memory wait states,
// branches, stall, illegal/halt, reset and (with MC_SEQ_WDOG_EN) the watchdog.
module tb_mc_seq_core;

    localparam int TB_WDOG = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req, imem_ready, dmem_ready, alu_zero, stall;
    logic [15:0] imem_addr, imem_rdata, alu_result, pc, instr;
    logic [3:0]  opcode;
    logic [2:0]  state;
    logic        ir_write, reg_write, mem_to_reg, mem_read, mem_write;
    logic        illegal, halted, wdog_err;
    logic [31:0] instret;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int c0     = 0;
    int bad    = 0;

    mc_seq_core #(.WDOG_CYCLES(TB_WDOG)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .dmem_ready(dmem_ready),
        .alu_zero(alu_zero), .alu_result(alu_result), .stall(stall), .pc(pc),
        .instr(instr), .opcode(opcode), .state(state), .ir_write(ir_write),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .mem_read(mem_read),
        .mem_write(mem_write), .illegal(illegal), .halted(halted),
        .instret(instret), .wdog_err(wdog_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one branch/jump from FETCH back to FETCH and checks the landing PC.
    task automatic run_ctrl(input string tag, input logic [15:0] word, input logic z,
                            input logic [15:0] tgt, input logic [15:0] exp_pc,
                            input logic [31:0] exp_ret);
        imem_rdata = word;
        alu_zero   = z;
        alu_result = tgt;
        c0 = cyc;
        step(); step(); step();
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_addr"}, 32'(imem_addr), 32'(exp_pc));
        chk({tag, "_instret"}, instret, exp_ret);
        chk({tag, "_lat"}, 32'(cyc - c0), 32'd3);
    endtask

    initial begin
        imem_ready = 1'b0; imem_rdata = '0; dmem_ready = 1'b0;
        alu_zero = 1'b0; alu_result = '0; stall = 1'b0;

        // Reset values
        #12;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_instret", instret, 32'd0);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_strobes", {27'd0, ir_write, reg_write, mem_read, mem_write, illegal}, 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_wdog", 32'(wdog_err), 32'd0);

        // R-type: FETCH, DECODE, EXEC, WB
        rst = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 16'h0123;
        #1;
        chk("rt_imem_req", 32'(imem_req), 32'd1);
        chk("rt_ir_write_c1", 32'(ir_write), 32'd1);
        chk("rt_addr", 32'(imem_addr), 32'd0);
        step();
        chk("rt_dec_state", 32'(state), 32'd1);
        chk("rt_pc", 32'(pc), 32'd2);
        chk("rt_instr", 32'(instr), 32'h0123);
        chk("rt_ir_write_off", 32'(ir_write), 32'd0);
        step();
        chk("rt_exec_state", 32'(state), 32'd2);
        step();
        chk("rt_wb_reg_write", 32'(reg_write), 32'd1);
        chk("rt_wb_mem_to_reg", 32'(mem_to_reg), 32'd0);
        step();
        chk("rt_instret", instret, 32'd1);
        chk("rt_back_fetch", 32'(state), 32'd0);

        // LW with three memory wait cycles
        imem_rdata = 16'h1000;
        c0 = cyc;
        step();
        chk("lw_opcode", 32'(opcode), 32'd1);
        chk("lw_pc", 32'(pc), 32'd4);
        step();
        step();
        for (int k = 0; k < 3; k++) begin
            chk("lw_mem_read_wait", {30'd0, mem_read, mem_write}, 32'd2);
            step();
        end
        dmem_ready = 1'b1;
        chk("lw_mem_read_last", {30'd0, mem_read, mem_write}, 32'd2);
        chk("lw_mem_state", 32'(state), 32'd3);
        step();
        dmem_ready = 1'b0;
        chk("lw_wb_state", 32'(state), 32'd4);
        chk("lw_reg_write", 32'(reg_write), 32'd1);
        chk("lw_mem_to_reg", 32'(mem_to_reg), 32'd1);
        chk("lw_instret_pre", instret, 32'd1);
        step();
        chk("lw_instret", instret, 32'd2);
        chk("lw_latency", 32'(cyc - c0), 32'd8);

        // Branches and jump, ending on a wrap of the PC
        run_ctrl("beq_t", 16'h3000, 1'b1, 16'h0040, 16'h0040, 32'd3);
        run_ctrl("beq_n", 16'h3000, 1'b0, 16'h0080, 16'h0042, 32'd4);
        run_ctrl("bne_t", 16'h4000, 1'b0, 16'h0100, 16'h0100, 32'd5);
        run_ctrl("jmp",   16'h5000, 1'b1, 16'hFFFE, 16'hFFFE, 32'd6);

        // ADDI stalled in EXEC
        imem_rdata = 16'h6000;
        step();
        chk("wrap_pc", 32'(pc), 32'd0);
        step();
        chk("addi_exec", 32'(state), 32'd2);
        stall = 1'b1;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (state !== 3'd2 || pc !== 16'd0 || reg_write !== 1'b0 || illegal !== 1'b0 ||
                mem_read !== 1'b0 || mem_write !== 1'b0 || instret !== 32'd6) bad++;
        end
        chk("stall_frozen", 32'(bad), 32'd0);
        stall = 1'b0;
        step();
        chk("stall_wb_state", 32'(state), 32'd4);
        chk("stall_wb_reg_write", 32'(reg_write), 32'd1);
        step();
        chk("addi_instret", instret, 32'd7);

        // Unknown opcode
        imem_rdata = 16'hE000;
        step();
        step();
        chk("ill_pulse", 32'(illegal), 32'd1);
        step();
        chk("ill_clear", 32'(illegal), 32'd0);
        chk("ill_state", 32'(state), 32'd0);
        chk("ill_instret", instret, 32'd7);
        chk("ill_pc", 32'(pc), 32'd2);

        // HALT is sticky and silent
        imem_rdata = 16'hF000;
        step();
        step();
        chk("halt_state", 32'(state), 32'd5);
        chk("halt_flag", 32'(halted), 32'd1);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (imem_req !== 1'b0 || state !== 3'd5) bad++;
        end
        chk("halt_no_req", 32'(bad), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst2_state", 32'(state), 32'd0);
        chk("rst2_pc", 32'(pc), 32'd0);
        chk("rst2_halted", 32'(halted), 32'd0);
        chk("rst2_instret", instret, 32'd0);
        chk("rst2_imem_req", 32'(imem_req), 32'd0);
        #3;
        rst = 1'b1;
        imem_ready = 1'b0;

`ifdef MC_SEQ_WDOG_EN
        for (int k = 0; k < TB_WDOG - 1; k++) step();
        chk("wdog_not_yet", 32'(wdog_err), 32'd0);
        step();
        chk("wdog_err", 32'(wdog_err), 32'd1);
        chk("wdog_state", 32'(state), 32'd5);
`else
        for (int k = 0; k < 20; k++) step();
        chk("nowdog_err", 32'(wdog_err), 32'd0);
        chk("nowdog_state", 32'(state), 32'd0);
        chk("nowdog_req", 32'(imem_req), 32'd1);
`endif

        // Reset while a store waits on the data port
        rst = 1'b0;
        #1;
        rst = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 16'h2000;
        dmem_ready = 1'b0;
        step();
        step();
        step();
        chk("sw_mem_strobes", {30'd0, mem_read, mem_write}, 32'd1);
        rst = 1'b0;
        #1;
        chk("sw_abort_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        chk("sw_abort_state", 32'(state), 32'd0);
        rst = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
